// File: rtl/simmem_pkg.sv
// Shared constants for the simulated memory controller.
// Bank capacities and the default release counter width.
package simmem_pkg;

    localparam int unsigned WriteRespBankCapacity = 16;
    localparam int unsigned ReadDataBankCapacity  = 16;
    localparam int unsigned DefaultCntWidth       = 32;

endpackage

// File: rtl/simmem_rr_picker.sv
// Combinational round-robin picker: first request at or above the
// pointer, otherwise the lowest request overall.
module simmem_rr_picker
    import simmem_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_pick,
    output logic                 o_valid
);

    logic [N-1:0] w_masked;
    logic [N-1:0] w_hi;
    logic [N-1:0] w_lo;

    always_comb begin
        w_masked = '0;
        for (int i = 0; i < N; i++) begin
            w_masked[i] = i_req[i] && (i >= int'(i_ptr));
        end
    end

    // x & -x isolates the lowest set bit
    assign w_hi    = w_masked & (~w_masked + N'(1));
    assign w_lo    = i_req & (~i_req + N'(1));
    assign o_pick  = (|w_masked) ? w_hi : w_lo;
    assign o_valid = |i_req;

endmodule

// File: rtl/simmem_release_scheduler.sv
// Round-robin release scheduler: issues one eligible bank slot at a
// time to a response bank over a valid/ready handshake.
module simmem_release_scheduler
    import simmem_pkg::*;
#(
    parameter int unsigned Capacity = 16,
    parameter int unsigned CntWidth = DefaultCntWidth
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [Capacity-1:0] release_en_mhot_i,
    output logic                grant_valid_o,
    output logic [Capacity-1:0] grant_onehot_o,
    input  logic                bank_ready_i,
    output logic [Capacity-1:0] released_onehot_o,
    output logic [CntWidth-1:0] release_cnt_o
);

    localparam int unsigned PtrW = $clog2(Capacity);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [Capacity-1:0] r_grant;
    logic [Capacity-1:0] w_grant_d;
    logic [PtrW-1:0]     r_ptr;
    logic [PtrW-1:0]     w_ptr_d;
    logic [CntWidth-1:0] r_cnt;
    logic [CntWidth-1:0] w_cnt_d;

    logic [PtrW-1:0]     w_gidx;
    logic [PtrW-1:0]     w_ptr_inc;
    logic [Capacity-1:0] w_pick_req;
    logic [PtrW-1:0]     w_pick_ptr;
    logic [Capacity-1:0] w_pick;
    logic                w_pick_vld;

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < Capacity; i++) begin
            if (r_grant[i]) w_gidx = PtrW'(i);
        end
    end

    assign w_ptr_inc = (w_gidx == PtrW'(Capacity - 1)) ? '0
                                                        : w_gidx + PtrW'(1);

    // In OFFER the picker prepares the back-to-back follow-up grant
    assign w_pick_req = (r_state == OFFER) ? (release_en_mhot_i & ~r_grant)
                                           : release_en_mhot_i;
    assign w_pick_ptr = (r_state == OFFER) ? w_ptr_inc : r_ptr;

    simmem_rr_picker #(
        .N (Capacity)
    ) u_picker (
        .i_req   (w_pick_req),
        .i_ptr   (w_pick_ptr),
        .o_pick  (w_pick),
        .o_valid (w_pick_vld)
    );

    always_comb begin
        w_state_d         = r_state;
        w_grant_d         = r_grant;
        w_ptr_d           = r_ptr;
        w_cnt_d           = r_cnt;
        grant_valid_o     = 1'b0;
        grant_onehot_o    = '0;
        released_onehot_o = '0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_grant_d = w_pick;
                    w_state_d = OFFER;
                end
            end
            OFFER: begin
                grant_valid_o  = 1'b1;
                grant_onehot_o = r_grant;
                if (bank_ready_i) begin
                    released_onehot_o = r_grant;
                    w_ptr_d           = w_ptr_inc;
                    w_cnt_d           = r_cnt + CntWidth'(1);
                    if (w_pick_vld) begin
                        w_grant_d = w_pick;
                    end else begin
                        w_grant_d = '0;
                        w_state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_grant <= w_grant_d;
            r_ptr   <= w_ptr_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign release_cnt_o = r_cnt;

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Directed and random checks of simmem_release_scheduler against a
// slot-index reference model (Capacity=4, CntWidth=4).
module tb_simmem_release_scheduler;

    localparam int C = 4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [C-1:0] release_en = '0;
    logic         bank_ready = 1'b0;
    logic         grant_valid;
    logic [C-1:0] grant_onehot;
    logic [C-1:0] released;
    logic [W-1:0] release_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: pending grant as a slot index
    bit m_offer = 0;
    int m_gidx  = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    logic [C-1:0] obs_g;
    logic [C-1:0] obs_r;
    logic         obs_v;
    logic [W-1:0] obs_cnt;

    always #5 clk = ~clk;

    simmem_release_scheduler #(
        .Capacity (C),
        .CntWidth (W)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .release_en_mhot_i (release_en),
        .grant_valid_o     (grant_valid),
        .grant_onehot_o    (grant_onehot),
        .bank_ready_i      (bank_ready),
        .released_onehot_o (released),
        .release_cnt_o     (release_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mpick(input logic [C-1:0] v, input int p);
        for (int k = 0; k < C; k++) begin
            int i;
            i = (p + k) % C;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // called just after a rising edge; returns just after the next one
    task automatic step(input logic [C-1:0] en, input logic rdy);
        logic [C-1:0] one;
        logic [C-1:0] e_g;
        logic [C-1:0] e_r;
        int           p;
        one        = 1;
        release_en = en;
        bank_ready = rdy;
        e_g = m_offer ? (one << m_gidx) : '0;
        e_r = (m_offer && rdy) ? e_g : '0;
        @(negedge clk);
        obs_v   = grant_valid;
        obs_g   = grant_onehot;
        obs_r   = released;
        obs_cnt = release_cnt;
        chk("valid", 32'(obs_v), 32'(m_offer));
        chk("grant", 32'(obs_g), 32'(e_g));
        chk("released", 32'(obs_r), 32'(e_r));
        chk("cnt", 32'(obs_cnt), 32'(m_cnt % 16));
        @(posedge clk);
        if (!m_offer) begin
            p = mpick(en, m_ptr);
            if (p >= 0) begin
                m_offer = 1;
                m_gidx  = p;
            end
        end else if (rdy) begin
            m_ptr = (m_gidx + 1) % C;
            m_cnt = m_cnt + 1;
            p = mpick(en & ~(one << m_gidx), m_ptr);
            if (p >= 0) m_gidx = p;
            else m_offer = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_offer = 0;
        m_gidx  = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    initial begin
        bank_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_grant", 32'(grant_onehot), 32'd0);
        chk("rst_released", 32'(released), 32'd0);
        chk("rst_cnt", 32'(release_cnt), 32'd0);
        @(posedge clk);
        #1;
        do_reset();

        // single release
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        chk("single_grant", 32'(obs_g), 32'b0100);
        chk("single_rel", 32'(obs_r), 32'b0100);
        step(4'b0000, 1'b1);
        chk("single_idle", 32'(obs_v), 32'd0);
        chk("single_cnt", 32'(obs_cnt), 32'd1);

        // round robin with bits cleared on release
        do_reset();
        step(4'b1011, 1'b1);
        step(4'b1011, 1'b1);
        chk("rr_g0", 32'(obs_g), 32'b0001);
        step(4'b1010, 1'b1);
        chk("rr_g1", 32'(obs_g), 32'b0010);
        step(4'b1000, 1'b1);
        chk("rr_g3", 32'(obs_g), 32'b1000);
        step(4'b0000, 1'b1);
        chk("rr_idle", 32'(obs_v), 32'd0);

        // backpressure, enables toggling during the stall
        step(4'b0010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step((i % 2 == 0) ? 4'b1110 : 4'b0010, 1'b0);
            chk("bp_grant", 32'(obs_g), 32'b0010);
            chk("bp_norel", 32'(obs_r), 32'd0);
        end
        step(4'b1110, 1'b1);
        chk("bp_rel", 32'(obs_r), 32'b0010);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);

        // wrap-around from pointer 3
        do_reset();
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b1001, 1'b1);
        step(4'b1001, 1'b1);
        chk("wrap_g3", 32'(obs_g), 32'b1000);
        step(4'b0001, 1'b1);
        chk("wrap_g0", 32'(obs_g), 32'b0001);
        step(4'b0011, 1'b1);
        step(4'b0011, 1'b1);
        chk("wrap_ptr1", 32'(obs_g), 32'b0010);

        // reset while an offer is pending
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        chk("mid_valid_pre", 32'(obs_v), 32'd1);
        bank_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_valid", 32'(grant_valid), 32'd0);
        chk("mid_grant", 32'(grant_onehot), 32'd0);
        chk("mid_rel", 32'(released), 32'd0);
        chk("mid_cnt", 32'(release_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_offer = 0;
        m_gidx  = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b1);
        chk("post_rst_g1", 32'(obs_g), 32'b0010);

        // counter wrap
        do_reset();
        step(4'b1111, 1'b1);
        for (int i = 0; i < 16; i++) step(4'b1111, 1'b1);
        chk("cnt_15", 32'(obs_cnt), 32'd15);
        step(4'b0000, 1'b1);
        chk("cnt_wrap", 32'(obs_cnt), 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(C'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/simmem_release_scheduler.md
# simmem_release_scheduler

Round-robin release scheduler between the delay calculator and one response bank (write-response or read-data). It takes the delay calculator's multi-hot release-enable vector and issues exactly one bank slot at a time to the bank, using a valid/ready handshake. It reports each completed release back to the delay calculator as a one-hot pulse and keeps a release counter. One instance is used per response bank.

## Interface
Parameters:
- Capacity, 16, number of bank slots; must be ≥ 2. Set to simmem_pkg::WriteRespBankCapacity or ReadDataBankCapacity.
- CntWidth, 32, width of the release counter.

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- release_en_mhot_i  in  Capacity  slots eligible for release, from the delay calculator.
- grant_valid_o  out  1  a slot grant is offered to the bank.
- grant_onehot_o  out  Capacity  slot being offered; all-zero when grant_valid_o=0.
- bank_ready_i  in  1  the bank accepts the offered grant.
- released_onehot_o  out  Capacity  one-cycle pulse of the released slot, to the delay calculator.
- release_cnt_o  out  CntWidth  total handshakes since reset; wraps modulo 2^CntWidth.

## Operation
- State machine with two states.
  - IDLE: grant_valid_o=0. If release_en_mhot_i≠0, pick a slot and load grant_q; next state is OFFER.
  - OFFER: grant_valid_o=1 and grant_onehot_o=grant_q.
    - If bank_ready_i=0, stay in OFFER.
    - If bank_ready_i=1, a handshake occurs.
- Pick rule: take the first set bit of release_en_mhot_i at index ≥ rr_ptr_q. If there is none, take the lowest set bit (wrap-around). Index arithmetic is modulo Capacity.
- On handshake:
  - released_onehot_o=grant_q in the same cycle (combinational from state and bank_ready_i).
  - rr_ptr_q ← granted index+1; the pointer wraps from Capacity-1 to 0.
  - release_cnt_o increments by 1.
  - Re-pick from release_en_mhot_i & ~grant_q. If the result is non-empty, load the new grant and stay in OFFER (back-to-back, one release per cycle). Otherwise go to IDLE.
- While in OFFER, grant_q is sticky. Changes to release_en_mhot_i, including deassertion of the granted bit, are ignored until the handshake.
- released_onehot_o is all-zero in every non-handshake cycle, and never has more than one bit set.
- Reset, including mid-offer: state=IDLE, grant_q=0, rr_ptr_q=0, counter=0. All outputs are 0 immediately (asynchronously) and stay 0 until the first edge after rst_i falls.

## Timing
- Enable to grant: a release-enable bit sampled set at edge t gives grant_valid_o=1 from cycle t+1 (one registered stage). There is no combinational path from release_en_mhot_i to the grant outputs.
- Throughput: one release per cycle while the bank holds bank_ready_i=1 and further slots are eligible.
- Release pulse: released_onehot_o and the counter update coincide with the handshake cycle. The counter value is visible from the following cycle.
- Handshake rule (AXI-style): once grant_valid_o rises, grant_valid_o and grant_onehot_o stay stable until bank_ready_i=1 is sampled.
- bank_ready_i may be asserted before grant_valid_o. It has no effect while no grant is valid.

## Structure
- simmem_pkg already holds WriteRespBankCapacity and ReadDataBankCapacity. Add a shared constant for the default CntWidth there. No new typedefs.
- Sub-module simmem_rr_picker: purely combinational. Inputs are the request vector and the pointer; outputs are the one-hot pick and a valid flag. It is reused by future arbiters.
- Top-level contents: the state register, grant_q, rr_ptr_q ($clog2(Capacity) bits) and the counter.

## Test plan
- Single release, Capacity=4, bank_ready_i=1:
  - Stimulus: release_en=0b0100 at cycle 0.
  - Response: grant_onehot_o=0b0100 with valid in cycle 1; released_onehot_o=0b0100 in cycle 1; valid=0 in cycle 2; release_cnt_o=1; rr_ptr=3.
- Round robin, bank_ready_i=1:
  - Stimulus: release_en=0b1011, with the bench clearing each bit on its release pulse.
  - Response: grants 0b0001, 0b0010, 0b1000 in cycles 1, 2, 3 back-to-back, then IDLE.
- Backpressure:
  - Stimulus: bank_ready_i=0 for 5 cycles with the grant on slot 1; release_en toggles between 0b0010 and 0b1110 during the stall.
  - Response: grant_onehot_o stays 0b0010 and valid stays 1 throughout; released_onehot_o=0 until ready rises, then a single pulse of 0b0010.
- Wrap-around:
  - Stimulus: rr_ptr=3 (after releasing slot 2); release_en=0b1001.
  - Response: slot 3 is granted first, then slot 0; rr_ptr ends at 1.
- Reset mid-offer:
  - Stimulus: assert rst_i while grant_valid_o=1.
  - Response: all outputs are 0 in the same cycle; after release of reset with release_en=0b0010, the grant goes to slot 1 (rr_ptr=0).
- Counter wrap:
  - Stimulus: CntWidth=4 with 16 consecutive releases.
  - Response: release_cnt_o reads 15, then 0.
